add8_cla: RTL and testbench

Registered 8-bit carry-lookahead adder for the ALU datapath. It computes A + B + Cin with a flat lookahead carry network (no ripple chain). The 8-bit sum, the per-bit carry-in vector and the carry-out are registered on the clock. It serves as the building block for the 32-bit ALU adder and exposes internal carries for debug and cascading.

---
 rtl/add8_cla_if.sv | 37 +++
 rtl/add8_cla.sv | 75 +++++++
 tb/tb_add8_cla.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/add8_cla_if.sv
// add8_cla_if: operand/result bundle for the registered 8-bit lookahead adder.
// Latency: n/a (wires only); the adder registers results one clock after sampling.
// Backpressure: none; a new operand triple may be presented every cycle.
//
// Signals:
//   A, B       8-bit operands (unsigned or two's complement, treated alike)
//   Cin        carry into bit 0
//   S          registered sum, (A + B + Cin) mod 256
//   carry_bits registered carry into each bit position (bit 0 = Cin)
//   Cout       registered carry out of bit 7
// master: operand source / result sink.  slave: the adder itself.
interface add8_cla_if;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic [7:0] carry_bits;
  logic       Cout;

  modport master (
    output A,
    output B,
    output Cin,
    input  S,
    input  carry_bits,
    input  Cout
  );

  modport slave (
    input  A,
    input  B,
    input  Cin,
    output S,
    output carry_bits,
    output Cout
  );
endinterface

// File: rtl/add8_cla.sv
// add8_cla: registered 8-bit adder with a flat carry-lookahead network (no ripple).
// Latency: 1 cycle; inputs sampled at a rising clock edge appear after that edge.
// Backpressure: none; accepts one operand triple per cycle, fully pipelined.
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-high; clears S, carry_bits and Cout immediately
//   bus    add8_cla_if.slave: A, B, Cin in; S, carry_bits, Cout out (registered)
module add8_cla (
  input  logic        clock,
  input  logic        reset,
  add8_cla_if.slave   bus
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic [7:0] sum;

  // Carry into bit position pos, written as an independent sum of products:
  // the Cin term ANDed with every propagate below pos, plus one term per
  // generate bit j < pos ANDed with the propagates strictly between j and pos.
  // No term depends on another carry, so the depth stays flat for every bit.
  function automatic logic carry_into(
    input logic [7:0] g,
    input logic [7:0] p,
    input logic       cin,
    input int         pos
  );
    logic acc;
    logic term;
    acc  = 1'b0;
    term = cin;
    for (int k = 0; k < 8; k++) begin
      if (k < pos) term = term & p[k];
    end
    acc = acc | term;
    for (int j = 0; j < 8; j++) begin
      if (j < pos) begin
        term = g[j];
        for (int k = 0; k < 8; k++) begin
          if ((k > j) && (k < pos)) term = term & p[k];
        end
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  always_comb begin
    gen   = bus.A & bus.B;
    prop  = bus.A ^ bus.B;
    carry = '0;
    carry[0] = bus.Cin;
    for (int i = 1; i <= 8; i++) begin
      carry[i] = carry_into(gen, prop, bus.Cin, i);
    end
    sum = prop ^ carry[7:0];
  end

  // Sum, carry vector and carry-out are captured on the same edge so they
  // always describe one operand triple.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.S          <= 8'h00;
      bus.carry_bits <= 8'h00;
      bus.Cout       <= 1'b0;
    end else begin
      bus.S          <= sum;
      bus.carry_bits <= carry[7:0];
      bus.Cout       <= carry[8];
    end
  end

endmodule

// File: tb/tb_add8_cla.sv
module tb_add8_cla;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  add8_cla_if bus ();

  add8_cla dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition. The carry into bit i is bit i of the
  // sum of the operands' low i bits plus Cin.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic [7:0] cb, output logic co);
    int full;
    int mask;
    full = int'(a) + int'(b) + int'(cin);
    s    = full[7:0];
    co   = full[8];
    for (int i = 0; i < 8; i++) begin
      mask  = (1 << i) - 1;
      cb[i] = (((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> i) & 1;
    end
  endtask

  // Every-cycle compare against the model using the values sampled at the edge.
  always @(posedge clk) begin
    logic [7:0] sa, sb, es, ecb;
    logic       scin, srst, eco;
    sa = bus.A; sb = bus.B; scin = bus.Cin; srst = rst;
    if (srst) begin
      es = 8'h00; ecb = 8'h00; eco = 1'b0;
    end else begin
      model(sa, sb, scin, es, ecb, eco);
    end
    #1;
    check("cmp_S", {24'd0, bus.S}, {24'd0, es});
    check("cmp_carry_bits", {24'd0, bus.carry_bits}, {24'd0, ecb});
    check("cmp_Cout", {31'd0, bus.Cout}, {31'd0, eco});
  end

  // Drive at the falling edge, check hand-computed values just after the rising edge.
  task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic [7:0] ecb,
                       input logic eco);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = cin;
    @(posedge clk);
    #2;
    check({name, "_S"}, {24'd0, bus.S}, {24'd0, es});
    check({name, "_cb"}, {24'd0, bus.carry_bits}, {24'd0, ecb});
    check({name, "_Cout"}, {31'd0, bus.Cout}, {31'd0, eco});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.A = 8'h55; bus.B = 8'h22; bus.Cin = 1'b1;
    #1;
    check("reset_S", {24'd0, bus.S}, 32'h0);
    check("reset_cb", {24'd0, bus.carry_bits}, 32'h0);
    check("reset_Cout", {31'd0, bus.Cout}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("reset_hold_S", {24'd0, bus.S}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    apply("simple",   8'h01, 8'h01, 1'b0, 8'h02, 8'h02, 1'b0);
    apply("prop_a5",  8'hA5, 8'h5A, 1'b1, 8'h00, 8'hFF, 1'b1);
    apply("prop_ff",  8'hFF, 8'h01, 1'b0, 8'h00, 8'hFE, 1'b1);
    apply("ffff",     8'hFF, 8'hFF, 1'b0, 8'hFE, 8'hFE, 1'b1);
    apply("nocarry",  8'h77, 8'h88, 1'b0, 8'hFF, 8'h00, 1'b0);
    apply("zero",     8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

    // Back-to-back triples on consecutive edges: no bubbles.
    apply("bb0", 8'h01, 8'h02, 1'b0, 8'h03, 8'h00, 1'b0);
    apply("bb1", 8'h10, 8'h10, 1'b0, 8'h20, 8'h20, 1'b0);
    apply("bb2", 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1);
    apply("bb3", 8'h0F, 8'h01, 1'b0, 8'h10, 8'h1E, 1'b0);
    apply("bb4", 8'hF0, 8'h10, 1'b1, 8'h01, 8'hE1, 1'b1);

    // Async reset between edges, then release before the next edge.
    apply("mixed", 8'hAB, 8'hCD, 1'b1, 8'h79, 8'h1F, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_S", {24'd0, bus.S}, 32'h0);
    check("async_cb", {24'd0, bus.carry_bits}, 32'h0);
    check("async_Cout", {31'd0, bus.Cout}, 32'h0);
    bus.A = 8'h01; bus.B = 8'h01; bus.Cin = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("post_release_S", {24'd0, bus.S}, 32'h0);
    @(posedge clk);
    #2;
    check("first_edge_S", {24'd0, bus.S}, 32'h02);
    check("first_edge_cb", {24'd0, bus.carry_bits}, 32'h02);

    // Inputs changing mid-cycle do not disturb registered outputs.
    #1;
    bus.A = 8'hFF; bus.B = 8'hFF; bus.Cin = 1'b1;
    #1;
    check("midcycle_S", {24'd0, bus.S}, 32'h02);

    // Deterministic sweep, checked by the every-cycle compare.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.A   = 8'(i * 37 + 5);
      bus.B   = 8'(255 - i * 11);
      bus.Cin = i[0];
    end
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
